// File: rtl/ast_width_converter_pkg.sv
// Shared types and helpers for the Avalon-ST width converter.
// Byte counts, empty-field widths and conversion-mode selection.
package ast_width_pkg;

   typedef enum logic [1:0] {CONV_UP, CONV_DOWN, CONV_PASS} conv_mode_t;

   function automatic int bytes_of(input int w);
      return w / 8;
   endfunction

   function automatic int empty_w(input int w);
      return (w / 8 > 1) ? $clog2(w / 8) : 1;
   endfunction

   function automatic conv_mode_t mode_of(input int in_w, input int out_w);
      if (out_w > in_w) return CONV_UP;
      if (in_w > out_w) return CONV_DOWN;
      return CONV_PASS;
   endfunction

endpackage

// File: rtl/ast_width_converter_out_reg.sv
// One-entry valid/ready output register; contents hold while valid and not ready.
module ast_out_reg #(
   parameter int DATA_W    = 64,
   parameter int EMPTY_W   = 3,
   parameter int CHANNEL_W = 8
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [EMPTY_W-1:0]   in_empty,
   input  logic [CHANNEL_W-1:0] in_channel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [EMPTY_W-1:0]   out_empty,
   output logic [CHANNEL_W-1:0] out_channel
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (srst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_empty   <= '0;
         out_channel <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data    <= in_data;
            out_sop     <= in_sop;
            out_eop     <= in_eop;
            out_empty   <= in_empty;
            out_channel <= in_channel;
         end
      end
   end

endmodule

// File: rtl/ast_width_converter.sv
// Avalon-ST packet width converter: packs (upsize), unpacks (downsize) or
// registers (equal) beats, keeping sop/eop/channel and recomputing empty.
module ast_width_converter
   import ast_width_pkg::*;
#(
   parameter  int DATA_IN_W   = 64,
   parameter  int DATA_OUT_W  = 256,
   parameter  int CHANNEL_W   = 8,
   localparam int EMPTY_IN_W  = empty_w(DATA_IN_W),
   localparam int EMPTY_OUT_W = empty_w(DATA_OUT_W)
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic [DATA_IN_W-1:0]   snk_data_i,
   input  logic                   snk_startofpacket_i,
   input  logic                   snk_endofpacket_i,
   input  logic                   snk_valid_i,
   input  logic [EMPTY_IN_W-1:0]  snk_empty_i,
   input  logic [CHANNEL_W-1:0]   snk_channel_i,
   output logic                   snk_ready_o,
   output logic [DATA_OUT_W-1:0]  src_data_o,
   output logic                   src_startofpacket_o,
   output logic                   src_endofpacket_o,
   output logic                   src_valid_o,
   output logic [EMPTY_OUT_W-1:0] src_empty_o,
   output logic [CHANNEL_W-1:0]   src_channel_o,
   input  logic                   src_ready_i,
   output logic                   err_o
);

   localparam int         IN_BYTES  = bytes_of(DATA_IN_W);
   localparam int         OUT_BYTES = bytes_of(DATA_OUT_W);
   localparam int         SMALL_B   = (IN_BYTES < OUT_BYTES) ? IN_BYTES : OUT_BYTES;
   localparam int         LARGE_B   = (IN_BYTES < OUT_BYTES) ? OUT_BYTES : IN_BYTES;
   localparam int         RATIO     = LARGE_B / SMALL_B;
   localparam conv_mode_t MODE      = mode_of(DATA_IN_W, DATA_OUT_W);

   if ((DATA_IN_W % 8 != 0) || (DATA_OUT_W % 8 != 0) || (RATIO * SMALL_B != LARGE_B)) begin : g_bad_ratio
      $error("ast_width_converter: widths must be byte multiples with an integer ratio");
   end

   logic                   reg_in_valid;
   logic                   reg_in_ready;
   logic [DATA_OUT_W-1:0]  reg_in_data;
   logic                   reg_in_sop;
   logic                   reg_in_eop;
   logic [EMPTY_OUT_W-1:0] reg_in_empty;
   logic [CHANNEL_W-1:0]   reg_in_channel;
   logic [CHANNEL_W-1:0]   pkt_chan;
   logic [CHANNEL_W-1:0]   chan_now;

   assign chan_now = snk_startofpacket_i ? snk_channel_i : pkt_chan;

   always_ff @(posedge clk) begin
      if (srst)
         pkt_chan <= '0;
      else if (snk_valid_i && snk_ready_o && snk_startofpacket_i)
         pkt_chan <= snk_channel_i;
   end

   if (MODE == CONV_UP) begin : g_up
      localparam int K_W = (RATIO > 1) ? $clog2(RATIO) : 1;
      logic [K_W-1:0]        k;
      logic [K_W-1:0]        k_eff;
      logic [DATA_OUT_W-1:0] acc;
      logic [DATA_OUT_W-1:0] word;
      logic                  acc_sop;
      logic                  sop_now;
      logic                  fin;
      logic                  hs;
      logic                  err_q;

      // A sop beat always restarts at slice 0, discarding any unfinished word.
      always_comb begin
         k_eff       = snk_startofpacket_i ? '0 : k;
         fin         = (k_eff == K_W'(RATIO - 1)) || snk_endofpacket_i;
         snk_ready_o = !srst && (reg_in_ready || !fin);
         hs          = snk_valid_i && snk_ready_o;
         word        = (k_eff == '0) ? '0 : acc;
         for (int unsigned i = 0; i < RATIO; i++) begin
            if (K_W'(RATIO - 1 - int'(i)) == k_eff)
               word[i*DATA_IN_W +: DATA_IN_W] = snk_data_i;
         end
         sop_now        = (k_eff == '0) ? snk_startofpacket_i : acc_sop;
         reg_in_valid   = hs && fin;
         reg_in_data    = word;
         reg_in_sop     = sop_now;
         reg_in_eop     = snk_endofpacket_i;
         reg_in_empty   = snk_endofpacket_i ?
            EMPTY_OUT_W'((RATIO - 1 - int'(k_eff)) * IN_BYTES + int'(snk_empty_i)) : '0;
         reg_in_channel = chan_now;
      end

      always_ff @(posedge clk) begin
         if (srst) begin
            k       <= '0;
            acc     <= '0;
            acc_sop <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            err_q <= hs && snk_startofpacket_i && (k != '0);
            if (hs) begin
               if (fin) begin
                  k <= '0;
               end else begin
                  k       <= k_eff + K_W'(1);
                  acc     <= word;
                  acc_sop <= sop_now;
               end
            end
         end
      end

      assign err_o = err_q;
   end else if (MODE == CONV_DOWN) begin : g_down
      localparam int K_W = (RATIO > 1) ? $clog2(RATIO) : 1;
      logic [DATA_IN_W-1:0]   hold;
      logic                   hold_valid;
      logic                   hold_sop;
      logic                   hold_eop;
      logic [EMPTY_OUT_W-1:0] last_empty;
      logic [CHANNEL_W-1:0]   hold_chan;
      logic [K_W-1:0]         idx;
      logic [K_W:0]           n_q;
      logic                   last;
      logic                   hs;
      int                     v_bytes;
      int                     n_slices;

      // Ready may rise while the last slice is leaving so words stream without a bubble.
      always_comb begin
         last        = (({1'b0, idx} + (K_W+1)'(1)) == n_q);
         snk_ready_o = !srst && (!hold_valid || (last && reg_in_ready));
         hs          = snk_valid_i && snk_ready_o;
         v_bytes     = IN_BYTES - (snk_endofpacket_i ? int'(snk_empty_i) : 0);
         n_slices    = (v_bytes + OUT_BYTES - 1) / OUT_BYTES;
         if (n_slices < 1) n_slices = 1;
         reg_in_valid = hold_valid;
         reg_in_data  = '0;
         for (int unsigned i = 0; i < RATIO; i++) begin
            if (K_W'(RATIO - 1 - int'(i)) == idx)
               reg_in_data = hold[i*DATA_OUT_W +: DATA_OUT_W];
         end
         reg_in_sop     = hold_sop && (idx == '0);
         reg_in_eop     = hold_eop && last;
         reg_in_empty   = (hold_eop && last) ? last_empty : '0;
         reg_in_channel = hold_chan;
      end

      always_ff @(posedge clk) begin
         if (srst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            hold_sop   <= 1'b0;
            hold_eop   <= 1'b0;
            last_empty <= '0;
            hold_chan  <= '0;
            idx        <= '0;
            n_q        <= '0;
         end else begin
            if (hold_valid && reg_in_ready) begin
               if (last) hold_valid <= 1'b0;
               else      idx        <= idx + K_W'(1);
            end
            if (hs) begin
               hold       <= snk_data_i;
               hold_valid <= 1'b1;
               hold_sop   <= snk_startofpacket_i;
               hold_eop   <= snk_endofpacket_i;
               last_empty <= EMPTY_OUT_W'(n_slices * OUT_BYTES - v_bytes);
               hold_chan  <= chan_now;
               idx        <= '0;
               n_q        <= (K_W+1)'(n_slices);
            end
         end
      end

      assign err_o = 1'b0;
   end else begin : g_pass
      always_comb begin
         snk_ready_o    = !srst && reg_in_ready;
         reg_in_valid   = snk_valid_i && snk_ready_o;
         reg_in_data    = DATA_OUT_W'(snk_data_i);
         reg_in_sop     = snk_startofpacket_i;
         reg_in_eop     = snk_endofpacket_i;
         reg_in_empty   = EMPTY_OUT_W'(snk_empty_i);
         reg_in_channel = chan_now;
      end

      assign err_o = 1'b0;
   end

   ast_out_reg #(
      .DATA_W    (DATA_OUT_W),
      .EMPTY_W   (EMPTY_OUT_W),
      .CHANNEL_W (CHANNEL_W)
   ) u_out_reg (
      .clk         (clk),
      .srst        (srst),
      .in_valid    (reg_in_valid),
      .in_ready    (reg_in_ready),
      .in_data     (reg_in_data),
      .in_sop      (reg_in_sop),
      .in_eop      (reg_in_eop),
      .in_empty    (reg_in_empty),
      .in_channel  (reg_in_channel),
      .out_valid   (src_valid_o),
      .out_ready   (src_ready_i),
      .out_data    (src_data_o),
      .out_sop     (src_startofpacket_o),
      .out_eop     (src_endofpacket_o),
      .out_empty   (src_empty_o),
      .out_channel (src_channel_o)
   );

endmodule

// File: tb/tb_ast_width_converter.sv
// Bench for ast_width_converter: a 64->256 and a 256->64 instance, each
// checked beat-by-beat against an expected-output queue.
module tb_ast_width_converter;

   logic clk = 1'b0;
   logic srst;
   always #5 clk = ~clk;

   logic [63:0]  u_snk_data;
   logic         u_snk_sop, u_snk_eop, u_snk_valid, u_snk_ready;
   logic [2:0]   u_snk_empty;
   logic [7:0]   u_snk_ch;
   logic [255:0] u_src_data;
   logic         u_src_sop, u_src_eop, u_src_valid, u_src_ready, u_err;
   logic [4:0]   u_src_empty;
   logic [7:0]   u_src_ch;

   logic [255:0] d_snk_data;
   logic         d_snk_sop, d_snk_eop, d_snk_valid, d_snk_ready;
   logic [4:0]   d_snk_empty;
   logic [7:0]   d_snk_ch;
   logic [63:0]  d_src_data;
   logic         d_src_sop, d_src_eop, d_src_valid, d_src_ready, d_err;
   logic [2:0]   d_src_empty;
   logic [7:0]   d_src_ch;

   ast_width_converter #(.DATA_IN_W(64), .DATA_OUT_W(256), .CHANNEL_W(8)) u_up (
      .clk(clk), .srst(srst),
      .snk_data_i(u_snk_data), .snk_startofpacket_i(u_snk_sop), .snk_endofpacket_i(u_snk_eop),
      .snk_valid_i(u_snk_valid), .snk_empty_i(u_snk_empty), .snk_channel_i(u_snk_ch),
      .snk_ready_o(u_snk_ready),
      .src_data_o(u_src_data), .src_startofpacket_o(u_src_sop), .src_endofpacket_o(u_src_eop),
      .src_valid_o(u_src_valid), .src_empty_o(u_src_empty), .src_channel_o(u_src_ch),
      .src_ready_i(u_src_ready), .err_o(u_err)
   );

   ast_width_converter #(.DATA_IN_W(256), .DATA_OUT_W(64), .CHANNEL_W(8)) u_dn (
      .clk(clk), .srst(srst),
      .snk_data_i(d_snk_data), .snk_startofpacket_i(d_snk_sop), .snk_endofpacket_i(d_snk_eop),
      .snk_valid_i(d_snk_valid), .snk_empty_i(d_snk_empty), .snk_channel_i(d_snk_ch),
      .snk_ready_o(d_snk_ready),
      .src_data_o(d_src_data), .src_startofpacket_o(d_src_sop), .src_endofpacket_o(d_src_eop),
      .src_valid_o(d_src_valid), .src_empty_o(d_src_empty), .src_channel_o(d_src_ch),
      .src_ready_i(d_src_ready), .err_o(d_err)
   );

   typedef struct {
      logic [255:0] data;
      logic         sop;
      logic         eop;
      logic [4:0]   empty;
      logic [7:0]   ch;
   } beat_t;

   beat_t q_u[$];
   beat_t q_d[$];
   beat_t eu, ed;
   int    n_checks = 0;
   int    n_pass   = 0;
   int    err_u    = 0;
   int    err_d    = 0;
   int    rdy_mode = 0;
   bit    gap_en   = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Source-ready pattern: 0 always ready, 1 toggling, 2 random, 3 stalled.
   initial begin
      u_src_ready = 1'b1;
      d_src_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: begin u_src_ready = 1'b1; d_src_ready = 1'b1; end
            1: begin u_src_ready = ~u_src_ready; d_src_ready = ~d_src_ready; end
            2: begin u_src_ready = 1'($urandom_range(0, 1)); d_src_ready = 1'($urandom_range(0, 1)); end
            default: begin u_src_ready = 1'b0; d_src_ready = 1'b0; end
         endcase
      end
   end

   logic         pu_v = 0, pu_r = 0, pd_v = 0, pd_r = 0;
   logic [255:0] pu_d;
   logic [63:0]  pd_d;

   always @(negedge clk) begin
      if (srst) begin
         pu_v = 0;
      end else begin
         if (pu_v && !pu_r) begin
            check("up_hold_valid", 256'(u_src_valid), 256'd1);
            check("up_hold_data", u_src_data, pu_d);
         end
         if (u_src_valid && u_src_ready) begin
            check("up_beat_expected", 256'(q_u.size() != 0), 256'd1);
            if (q_u.size() != 0) begin
               eu = q_u.pop_front();
               check("up_data", u_src_data, eu.data);
               check("up_sop", 256'(u_src_sop), 256'(eu.sop));
               check("up_eop", 256'(u_src_eop), 256'(eu.eop));
               check("up_empty", 256'(u_src_empty), 256'(eu.empty));
               check("up_channel", 256'(u_src_ch), 256'(eu.ch));
            end
         end
         if (u_err) err_u++;
         pu_v = u_src_valid; pu_r = u_src_ready; pu_d = u_src_data;
      end
   end

   always @(negedge clk) begin
      if (srst) begin
         pd_v = 0;
      end else begin
         if (pd_v && !pd_r) begin
            check("dn_hold_valid", 256'(d_src_valid), 256'd1);
            check("dn_hold_data", 256'(d_src_data), 256'(pd_d));
         end
         if (d_src_valid && d_src_ready) begin
            check("dn_beat_expected", 256'(q_d.size() != 0), 256'd1);
            if (q_d.size() != 0) begin
               ed = q_d.pop_front();
               check("dn_data", 256'(d_src_data), ed.data);
               check("dn_sop", 256'(d_src_sop), 256'(ed.sop));
               check("dn_eop", 256'(d_src_eop), 256'(ed.eop));
               check("dn_empty", 256'(d_src_empty), 256'(ed.empty));
               check("dn_channel", 256'(d_src_ch), 256'(ed.ch));
            end
         end
         if (d_err) err_d++;
         pd_v = d_src_valid; pd_r = d_src_ready; pd_d = d_src_data;
      end
   end

   // Present one beat from posedge+1 and wait (bounded) for its handshake.
   task automatic drive_beat(input bit dn, input logic [255:0] data, input logic sop, input logic eop,
                             input logic [4:0] emp, input logic [7:0] ch, input bit chk_full);
      int t = 0;
      bit r;
      if (gap_en) while ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      if (dn) begin
         d_snk_data = data; d_snk_sop = sop; d_snk_eop = eop; d_snk_empty = emp; d_snk_ch = ch;
         d_snk_valid = 1'b1;
      end else begin
         u_snk_data = data[63:0]; u_snk_sop = sop; u_snk_eop = eop; u_snk_empty = emp[2:0];
         u_snk_ch = ch; u_snk_valid = 1'b1;
      end
      forever begin
         @(negedge clk);
         r = dn ? d_snk_ready : u_snk_ready;
         if (chk_full && t == 0) check("up_full_rate", 256'(r), 256'd1);
         @(posedge clk);
         #1;
         if (r) break;
         t++;
         if (t > 1000) begin check("snk_accept_timeout", 256'(t), 256'd0); break; end
      end
      if (dn) d_snk_valid = 1'b0;
      else    u_snk_valid = 1'b0;
   endtask

   task automatic send_up(input int nb, input logic [2:0] emp, input logic [7:0] ch,
                          input bit eop_end, input bit rnd, input bit chk_full);
      logic [255:0] acc = '0;
      logic [63:0]  bd;
      int           cnt = 0;
      bit           first = 1;
      bit           last;
      beat_t        e;
      for (int i = 0; i < nb; i++) begin
         last = (i == nb - 1);
         bd   = rnd ? {$urandom, $urandom} : {8{8'(8'h11 * (i + 1))}};
         acc  = {acc[191:0], bd};
         cnt++;
         if (cnt == 4 || (last && eop_end)) begin
            e.data  = acc << (64 * (4 - cnt));
            e.sop   = first;
            e.eop   = last && eop_end;
            e.empty = e.eop ? 5'((4 - cnt) * 8 + int'(emp)) : 5'd0;
            e.ch    = ch;
            q_u.push_back(e);
            first = 0;
            cnt   = 0;
            acc   = '0;
         end
         drive_beat(0, {192'd0, bd}, i == 0, last && eop_end, {2'b00, emp}, (i == 0) ? ch : ~ch, chk_full);
      end
   endtask

   task automatic send_dn(input int nw, input logic [4:0] emp, input logic [7:0] ch,
                          input logic [255:0] fixed, input bit rnd);
      logic [255:0] data;
      logic [63:0]  sl;
      int           v, n;
      bit           last;
      beat_t        e;
      for (int w = 0; w < nw; w++) begin
         data = rnd ? rand256() : fixed;
         last = (w == nw - 1);
         v    = last ? 32 - int'(emp) : 32;
         n    = (v + 7) / 8;
         for (int j = 0; j < n; j++) begin
            sl      = 64'(data >> (64 * (3 - j)));
            e.data  = {192'd0, sl};
            e.sop   = (w == 0) && (j == 0);
            e.eop   = last && (j == n - 1);
            e.empty = e.eop ? 5'(n * 8 - v) : 5'd0;
            e.ch    = ch;
            q_d.push_back(e);
         end
         drive_beat(1, data, w == 0, last, last ? emp : 5'd0, (w == 0) ? ch : ~ch, 0);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q_u.size() != 0 || q_d.size() != 0) && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      check("drain_pending", 256'(q_u.size() + q_d.size()), 256'd0);
      repeat (5) @(posedge clk);
      #1;
   endtask

   int e0;

   initial begin
      u_snk_data = '0; u_snk_sop = 0; u_snk_eop = 0; u_snk_valid = 0; u_snk_empty = '0; u_snk_ch = '0;
      d_snk_data = '0; d_snk_sop = 0; d_snk_eop = 0; d_snk_valid = 0; d_snk_empty = '0; d_snk_ch = '0;
      srst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_up_valid", 256'(u_src_valid), 256'd0);
      check("rst_up_flags", 256'({u_src_sop, u_src_eop, u_err}), 256'd0);
      check("rst_up_data", u_src_data, 256'd0);
      check("rst_up_empty_ch", 256'({u_src_empty, u_src_ch}), 256'd0);
      check("rst_up_snk_ready", 256'(u_snk_ready), 256'd0);
      check("rst_dn_valid", 256'(d_src_valid), 256'd0);
      check("rst_dn_snk_ready", 256'(d_snk_ready), 256'd0);
      @(posedge clk);
      #1;
      srst = 1'b0;

      // Packing, partial last word, single-word unpack
      send_up(4, 3'd0, 8'h5A, 1, 0, 1);
      send_up(8, 3'd3, 8'h3C, 1, 1, 1);
      drain();
      send_up(3, 3'd2, 8'h21, 1, 0, 0);
      drain();
      send_dn(1, 5'd20, 8'h77, 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, 0);
      drain();

      // Backpressure with source-ready toggling, then random, plus random sink gaps
      gap_en = 1;
      for (int m = 1; m <= 2; m++) begin
         rdy_mode = m;
         for (int p = 0; p < 6; p++) begin
            send_up($urandom_range(1, 9), 3'($urandom_range(0, 7)), 8'($urandom), 1, 1, 0);
            send_dn($urandom_range(1, 3), 5'($urandom_range(0, 31)), 8'($urandom), '0, 1);
         end
         drain();
      end
      gap_en   = 0;
      rdy_mode = 0;
      drain();

      // sop arriving with a partial word pending
      e0 = err_u;
      send_up(2, 3'd0, 8'hA1, 0, 1, 0);
      send_up(4, 3'd1, 8'hB2, 1, 0, 0);
      drain();
      check("up_err_pulses", 256'(err_u - e0), 256'd1);

      // Reset with a stalled output word and a partial word in flight
      e0 = err_u;
      rdy_mode = 3;
      @(posedge clk);
      #1;
      send_up(4, 3'd0, 8'hC3, 1, 1, 0);
      send_up(2, 3'd0, 8'hC4, 0, 1, 0);
      @(negedge clk);
      check("stall_up_valid", 256'(u_src_valid), 256'd1);
      @(posedge clk);
      #1;
      srst = 1'b1;
      q_u.delete();
      @(negedge clk);
      check("midrst_snk_ready", 256'(u_snk_ready), 256'd0);
      @(posedge clk);
      #1;
      srst     = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      check("midrst_up_valid", 256'(u_src_valid), 256'd0);
      @(posedge clk);
      #1;
      send_up(4, 3'd5, 8'hD4, 1, 1, 0);
      send_dn(2, 5'd3, 8'hE5, '0, 1);
      drain();
      check("midrst_no_err", 256'(err_u - e0), 256'd0);
      check("dn_err_never", 256'(err_d), 256'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
